// File: rtl/dpbe_fifo_ctrl.sv
// dpbe_fifo_ctrl: single-clock FIFO controller around an external dual-port
// byte-enable RAM (port A writes, port B reads), with a 2-entry output buffer
// that hides the RAM's one-cycle read latency and gives a first-word-fall-through pop.
module dpbe_fifo_ctrl #(
    parameter int W = 256,
    parameter int D = 64,
    localparam int AW = $clog2(D)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W-1:0]    s_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [W-1:0]    m_data,
    output logic [AW+1:0]   count,
    output logic            ram_ena,
    output logic [AW-1:0]   ram_addra,
    output logic [W/8-1:0]  ram_wea,
    output logic [W-1:0]    ram_dina,
    output logic            ram_enb,
    output logic [AW-1:0]   ram_addrb,
    input  logic [W-1:0]    ram_doutb
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(D);

    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic         pend_q, pend_d;
    logic [1:0]   buf_cnt_q, buf_cnt_d;
    logic [W-1:0] ob0_q, ob0_d, ob1_q, ob1_d;

    logic [AW:0]  mem_used;
    logic         full, mem_empty, push, pop, rd_issue;
    logic [2:0]   occ_after;
    logic [1:0]   cnt_after_pop;

    // Occupancy, handshakes and read-issue decision.
    always_comb begin
        mem_used  = wptr_q - rptr_q;
        full      = (mem_used == FULL_LVL);
        mem_empty = (wptr_q == rptr_q);
        s_ready   = !rst & !full;
        m_valid   = (buf_cnt_q != 2'd0);
        push      = s_valid & s_ready;
        pop       = m_valid & m_ready;
        // Buffer slots that will be claimed after this cycle's pop, counting
        // the word already in flight from the RAM.
        occ_after = {1'b0, buf_cnt_q} + {2'b00, pend_q} - {2'b00, pop};
        // Non-empty RAM implies rptr != wptr, so no same-address read/write.
        rd_issue  = !mem_empty & (occ_after < 3'd2);
        count     = {1'b0, mem_used} + {{AW{1'b0}}, buf_cnt_q}
                  + {{(AW+1){1'b0}}, pend_q};
        m_data    = ob0_q;
        ram_ena   = push;
        ram_addra = wptr_q[AW-1:0];
        ram_wea   = {(W/8){push}};
        ram_dina  = s_data;
        ram_enb   = rd_issue;
        ram_addrb = rptr_q[AW-1:0];
    end

    // Next-state: pointers, pending read flag, and output buffer shift/fill.
    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, push};
        rptr_d = rptr_q + {{AW{1'b0}}, rd_issue};
        pend_d = rd_issue;
        ob0_d  = ob0_q;
        ob1_d  = ob1_q;
        cnt_after_pop = buf_cnt_q - {1'b0, pop};
        if (pop) ob0_d = ob1_q;
        // Returning read data lands in the first slot free after the pop.
        if (pend_q) begin
            if (cnt_after_pop == 2'd0) ob0_d = ram_doutb;
            else                       ob1_d = ram_doutb;
        end
        buf_cnt_d = cnt_after_pop + {1'b0, pend_q};
    end

    // State registers; reset drops any in-flight read by clearing pend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            pend_q    <= 1'b0;
            buf_cnt_q <= 2'd0;
            ob0_q     <= '0;
            ob1_q     <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            pend_q    <= pend_d;
            buf_cnt_q <= buf_cnt_d;
            ob0_q     <= ob0_d;
            ob1_q     <= ob1_d;
        end
    end

endmodule

// File: tb/tb_dpbe_fifo_ctrl.sv
// tb_dpbe_fifo_ctrl: random and directed stimulus; accepted words go into a
// reference queue, a monitor pops and compares on every DUT pop, and the
// DUT count is checked against the queue depth every cycle.
module tb_dpbe_fifo_ctrl;
    localparam int W  = 256;
    localparam int D  = 64;
    localparam int AW = $clog2(D);

    logic           clk = 1'b0;
    logic           rst;
    logic           s_valid, s_ready, m_valid, m_ready;
    logic [W-1:0]   s_data, m_data;
    logic [AW+1:0]  count;
    logic           ram_ena, ram_enb;
    logic [AW-1:0]  ram_addra, ram_addrb;
    logic [W/8-1:0] ram_wea;
    logic [W-1:0]   ram_dina, ram_doutb;

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    dpbe_fifo_ctrl #(.W(W), .D(D)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count),
        .ram_ena(ram_ena), .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_dina(ram_dina),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    // External RAM: byte-enable write on port A, registered read on port B.
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (ram_ena)
            for (int b = 0; b < W/8; b++)
                if (ram_wea[b]) mem[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
        if (ram_enb) ram_doutb <= mem[ram_addrb];
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] pat(input int i);
        logic [31:0] v;
        v = i;
        return {(W/32){v}};
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] v;
        for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One cycle of stimulus; an accepted push becomes an expected pop.
    task automatic cyc(input logic sv, input logic [W-1:0] d, input logic mr, output logic acc);
        @(posedge clk); #1;
        s_valid = sv; s_data = d; m_ready = mr;
        @(negedge clk);
        acc = s_valid && s_ready;
        if (acc) exp_q.push_back(s_data);
    endtask

    task automatic drain_all(input int lim);
        logic acc;
        int k = 0;
        do begin
            cyc(1'b0, '0, 1'b1, acc);
            k++;
        end while ((m_valid || count != '0) && k < lim);
        cyc(1'b0, '0, 1'b1, acc);
        chk("drain_count", W'(count), '0);
        chk("drain_model_empty", W'(exp_q.size()), '0);
        chk("drain_m_valid", W'(m_valid), '0);
    endtask

    // Monitor: every DUT pop must match the oldest accepted word.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("pop_with_empty_model", W'(m_valid), '0);
            else                   chk("pop_data", m_data, exp_q.pop_front());
        end
    end

    // Occupancy: count must equal accepted-but-not-popped words.
    always begin
        @(posedge clk); #1;
        if (!rst) chk("count", W'(count), W'(exp_q.size()));
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   npop, nacc, gaps, k;
        logic seen, found;

        rst = 1'b1; s_valid = 1'b1; s_data = pat(7); m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_m_valid", W'(m_valid), '0);
        chk("rst_count",   W'(count),   '0);
        chk("rst_ram_ena", W'(ram_ena), '0);
        chk("rst_ram_enb", W'(ram_enb), '0);
        chk("rst_s_ready", W'(s_ready), '0);
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", W'(s_ready), W'(1));
        chk("idle_m_valid", W'(m_valid), '0);
        chk("idle_count",   W'(count),   '0);
        chk("idle_ram_ena", W'(ram_ena), '0);
        chk("idle_ram_enb", W'(ram_enb), '0);

        // Single word: two-edge latency to m_valid.
        cyc(1'b1, {(W/8){8'hA5}}, 1'b1, acc);
        chk("single_acc",  W'(acc),     W'(1));
        chk("single_ena",  W'(ram_ena), W'(1));
        chk("single_wea",  W'(ram_wea), W'({(W/8){1'b1}}));
        chk("single_dina", ram_dina,    {(W/8){8'hA5}});
        cyc(1'b0, '0, 1'b1, acc);
        chk("single_lat1", W'(m_valid), '0);
        chk("single_nowea", W'(ram_wea), '0);
        cyc(1'b0, '0, 1'b1, acc);
        chk("single_lat2", W'(m_valid), '0);
        cyc(1'b0, '0, 1'b1, acc);
        chk("single_lat3", W'(m_valid), W'(1));
        chk("single_data", m_data, {(W/8){8'hA5}});
        cyc(1'b0, '0, 1'b1, acc);
        chk("single_count0", W'(count), '0);
        chk("single_empty",  W'(m_valid), '0);

        // Fill: D+2 words fit (RAM plus output buffer), the next is refused.
        for (int i = 0; i < D + 2; i++) begin
            cyc(1'b1, pat(i), 1'b0, acc);
            chk("fill_acc", W'(acc), W'(1));
        end
        cyc(1'b1, pat(D + 2), 1'b0, acc);
        chk("fill_reject", W'(acc),     '0);
        chk("fill_s_ready", W'(s_ready), '0);
        chk("fill_count",  W'(count),   W'(D + 2));

        // Drain: D+2 consecutive pops; space frees after the first read.
        for (int i = 0; i < D + 2; i++) begin
            cyc(1'b0, '0, 1'b1, acc);
            chk("drain_valid", W'(m_valid), W'(1));
            if (i == 0) chk("drain_s_ready0", W'(s_ready), '0);
            if (i == 1) chk("drain_s_ready1", W'(s_ready), W'(1));
        end
        cyc(1'b0, '0, 1'b1, acc);
        chk("drained_valid", W'(m_valid), '0);
        chk("drained_count", W'(count),   '0);

        // Streaming: one pop per cycle after priming, pointers wrap past D.
        npop = 0; nacc = 0; gaps = 0; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(1'b1, pat(1000 + i), 1'b1, acc);
            if (acc) nacc++;
            if (m_valid) begin seen = 1'b1; npop++; end
            else if (seen) gaps++;
        end
        chk("stream_acc",  W'(nacc), W'(200));
        chk("stream_pops", W'(npop), W'(197));
        chk("stream_gaps", W'(gaps), '0);
        drain_all(20);

        // Random back-pressure.
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 9) < 6), rnd_word(), 1'($urandom_range(0, 9) < 6), acc);

        // Reset while a read is in flight.
        found = 1'b0; k = 0;
        while (!found && k < 200) begin
            cyc(1'($urandom_range(0, 9) < 6), rnd_word(), 1'($urandom_range(0, 9) < 6), acc);
            k++;
            if (ram_enb) found = 1'b1;
        end
        chk("pend_found", W'(found), W'(1));
        @(posedge clk); #1;
        rst = 1'b1; exp_q.delete(); s_valid = 1'b0; m_ready = 1'b1;
        #1;
        chk("midrst_m_valid", W'(m_valid), '0);
        chk("midrst_count",   W'(count),   '0);
        chk("midrst_s_ready", W'(s_ready), '0);
        chk("midrst_ram_enb", W'(ram_enb), '0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, '0, 1'b1, acc);
            chk("no_stale", W'(m_valid), '0);
        end
        chk("post_rst_count", W'(count), '0);

        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 9) < 6), rnd_word(), 1'($urandom_range(0, 9) < 6), acc);
        drain_all(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dpbe_fifo_ctrl.md
Name: dpbe_fifo_ctrl

Overview:
- Single-clock FIFO controller that drives an external W-bit x D-deep dual-port byte-enable RAM.
- Port A of the RAM is the write side; port B is the read side.
- Converts a valid/ready push stream into RAM writes, and RAM reads into a first-word-fall-through valid/ready pop stream.
- A 2-entry output buffer absorbs the RAM's 1-cycle read latency, so the block sustains one word per cycle in both directions.

Parameters:
- W, 256, data width in bits; multiple of 8.
- D, 64, RAM depth in words; power of two, >= 2.
- AW, clogb2(D), RAM address width; derived, not overridden.

Ports:
- clk  in  1  single clock; drives all logic and both RAM ports.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  push request.
- s_ready  out  1  push accept.
- s_data  in  W  push data.
- m_valid  out  1  pop data valid.
- m_ready  in  1  pop accept.
- m_data  out  W  pop data (head of FIFO).
- count  out  AW+2  total words held: RAM + in-flight read + output buffer; range 0..D+2.
- ram_ena  out  1  RAM port A enable.
- ram_addra  out  AW  RAM port A address.
- ram_wea  out  W/8  RAM port A byte write enables.
- ram_dina  out  W  RAM port A write data.
- ram_enb  out  1  RAM port B enable.
- ram_addrb  out  AW  RAM port B address.
- ram_doutb  in  W  RAM port B read data; registered, valid the cycle after ram_enb.
- The RAM's port B write enables are tied to zero at the integration level.

Behaviour:
- Reset (asynchronous): wptr=0, rptr=0 (both AW+1 bits), pend=0, output buffer empty.
  - Outputs during reset: m_valid=0, count=0, ram_ena=0, ram_enb=0, s_ready=0.
  - m_data is don't-care while m_valid=0.
- Derived quantities:
  - mem_used = wptr - rptr, modulo 2^(AW+1).
  - full = (mem_used == D); mem_empty = (wptr == rptr).
  - s_ready = !rst & !full (combinational).
- Push = s_valid & s_ready.
  - Same cycle: ram_ena=1, ram_addra=wptr[AW-1:0], ram_wea=all ones, ram_dina=s_data.
  - wptr increments at the clock edge.
  - With no push: ram_ena=0, ram_wea=0.
- Output buffer: 2 entries, ob0 (head, drives m_data) and ob1 (skid); buf_cnt is 0..2; m_valid = (buf_cnt != 0).
- Pop = m_valid & m_ready. On pop, ob1 shifts into ob0.
- Read issue:
  - Condition: ram_enb = !mem_empty & (buf_cnt + pend - pop < 2).
  - Action: ram_addrb = rptr[AW-1:0]; rptr increments; pend <= 1 next cycle, else 0.
  - The cycle after an issue, ram_doutb is written into the first free buffer slot, taking into account a pop in that same cycle.
- Read/write collision: a read is only issued when rptr != wptr, so no same-address read/write occurs in the same cycle.
- Latency: a word accepted at edge t into an empty FIFO gives m_valid=1 after edge t+2.
- Throughput: continuous push with m_ready held high gives one pop per cycle once primed.
- Ordering: strict FIFO; byte lanes are never partially written.
- Simultaneous push and pop: both proceed, and count stays constant.
- Push stall: when full, s_ready=0 and s_data is ignored. The output buffer still drains, after which reads free RAM space.
- Pop stall: when buf_cnt=0, m_valid=0 and m_ready is ignored.
- Pointer wrap: pointers wrap modulo 2^(AW+1); addresses wrap modulo D.
- Reset mid-operation clears all state immediately; in-flight read data is discarded.

Test Plan:
- Reset then idle: after rst deassert, s_ready=1, m_valid=0, count=0, ram_ena=0, ram_enb=0.
- Single word: push 0xA5…A5 at edge t, m_ready=1 → m_valid=1 after edge t+2 with m_data=0xA5…A5; ram_wea=all ones in the push cycle; count returns to 0 after the pop.
- Fill: m_ready=0, push D+2 words (0..65 for D=64) → s_ready drops after word 65 is accepted; count=66; word 66 is not accepted.
- Drain in order: from full, set m_ready=1 → pops 0..65 in order on 66 consecutive cycles; s_ready reasserts the cycle after the first RAM read frees a slot.
- Streaming: s_valid=1 and m_ready=1 for 200 cycles with incrementing data → after 2 cycles of priming, one pop per cycle in order; pointers wrap correctly past D.
- Random back-pressure plus mid-stream reset: random s_valid/m_ready; the scoreboard matches. Assert rst while pend=1 → m_valid=0 and count=0 immediately, and no stale word appears after release.
